central_buffer_write_arbiter: RTL
=================================

// Module: central_buffer_write_arbiter
// PURPOSE
//  Shares the single centralized-buffer write port (134b word + 16b addr, wr/ack) between NUM_REQ packet writers,
//  e.g. host-receive and network-receive interfaces. Round-robin arbitration at packet granularity: a grant is
//  locked from head word to tail word. Sits between the per-port buffer interfaces and the packet buffer RAM.
// PARAMETERS
//  NUM_REQ     4     number of requesters (2..8); the grant index width is 3 bits regardless of NUM_REQ.
//  LOCK_TMO    255   max idle cycles while locked that the block waits for the next word (1..255).
// PORTS
//  i_clk            in   1            single clock for all logic
//  i_rst            in   1            synchronous reset, active-high
//  iv_wdata         in   NUM_REQ*134  word per requester, slice k = [k*134+133:k*134]; bits[133:132] 01=head 11=mid 10=tail
//  iv_data_waddr    in   NUM_REQ*16   buffer write address per requester, slice k = [k*16+15:k*16]
//  i_data_wr        in   NUM_REQ      per-requester word valid; data/addr held stable until acked
//  o_wdata_ack      out  NUM_REQ      per-requester word accepted (1-cycle pulse)
//  ov_wdata         out  134          word to buffer
//  ov_data_waddr    out  16           address to buffer
//  o_data_wr        out  1            write valid to buffer; held until i_wdata_ack
//  i_wdata_ack      in   1            buffer accepted current word
//  ov_grant_id      out  3            index of locked requester (valid when o_lock=1)
//  o_lock           out  1            a packet is in progress
//  o_err_pulse      out  1            non-head word dropped in IDLE, or lock timeout
// BEHAVIOUR
//  - Reset (synchronous, active-high): state=IDLE, rr_ptr=0, tmo_cnt=0. All outputs 0.
//    A packet in progress is abandoned. No ack is issued in the reset cycle.
//  - States: IDLE -> ISSUE -> (WAIT_NEXT <-> ISSUE) -> IDLE.
//  - IDLE, head-request selection:
//    * Eligible requesters: i_data_wr[k]=1 and word type 01.
//    * Pick the first eligible requester searching k=rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//    * Register its word/addr into ov_wdata/ov_data_waddr and set o_data_wr=1, o_lock=1, ov_grant_id=k.
//    * Go to ISSUE. Latency: request seen at cycle n -> o_data_wr=1 at n+1.
//  - IDLE, non-head requests:
//    * A requester with i_data_wr=1 and type!=01 gets o_wdata_ack pulsed (word discarded) and o_err_pulse=1.
//    * The lowest such index is handled first. Its drop takes precedence over a grant only when no requester is eligible.
//  - ISSUE: o_data_wr stays 1 with stable data until i_wdata_ack=1.
//    * In the ack cycle: o_wdata_ack[grant]=1 (combinational from i_wdata_ack), and o_data_wr clears next cycle.
//    * Word type 10: go to IDLE, rr_ptr=grant+1 mod NUM_REQ, o_lock=0.
//    * Otherwise: go to WAIT_NEXT, tmo_cnt=0.
//  - WAIT_NEXT:
//    * If i_data_wr[grant]=1: register the word and go to ISSUE. Any type is accepted.
//      A type-01 word here is an upstream error; it is still forwarded.
//    * Otherwise tmo_cnt++.
//    * When tmo_cnt reaches LOCK_TMO: o_err_pulse=1, go to IDLE, rr_ptr=grant+1, o_lock=0.
//    * Other requesters' i_data_wr is ignored while locked; they get no ack.
//  - i_wdata_ack while o_data_wr=0 is ignored.
//  - A requester deasserting i_data_wr before ack is not supported; the registered word is still written.
//  - Throughput: one word per 2 cycles minimum while locked (ack cycle, reload cycle).
//    One idle cycle occurs between the tail ack and the next grant.
//  - rr_ptr wraps from NUM_REQ-1 to 0.
//    Simultaneous tail ack and new requests: the arbitration happens next cycle with the updated rr_ptr.
// TESTING
//  1. Reset, then req0 sends a 4-word packet (01,11,11,10) with addr 0x0010..0x0013 and the buffer acks 1 cycle after each
//     o_data_wr -> 4 writes in order, addrs match, o_wdata_ack[0] pulses 4 times, o_lock falls after the tail ack.
//  2. req0..req3 all hold head words at the same cycle after reset -> packets granted in order 0,1,2,3, no interleaving;
//     a second round starting with req1 and req0 requesting grants req1 first only if rr_ptr=1.
//  3. Buffer delays i_wdata_ack by 10 cycles on word 2 -> o_data_wr and ov_wdata hold stable for all 10 cycles;
//     no other requester is acked meanwhile.
//  4. req2 sends a head and then stops; LOCK_TMO=8 -> o_err_pulse exactly once, 8 cycles after entering WAIT_NEXT;
//     o_lock=0; pending req3 is granted on the next cycle.
//  5. req1 presents a middle word (11) in IDLE -> o_wdata_ack[1]=1 and o_err_pulse=1 in the same cycle, o_data_wr stays 0.
//  6. Assert i_rst for 1 cycle during ISSUE of word 2 -> next cycle all outputs 0 and state IDLE;
//     a fresh head from req3 is then granted normally.

Source files
------------

// File: rtl/central_buffer_write_arbiter.sv
// Round-robin, packet-locked arbiter for the shared centralized-buffer write port.
// A grant is held from the head word to the tail word; an idle lock times out after LOCK_TMO cycles.
module central_buffer_write_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int LOCK_TMO = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NUM_REQ*134-1:0] iv_wdata,
  input  logic [NUM_REQ*16-1:0]  iv_data_waddr,
  input  logic [NUM_REQ-1:0]     i_data_wr,
  output logic [NUM_REQ-1:0]     o_wdata_ack,
  output logic [133:0]           ov_wdata,
  output logic [15:0]            ov_data_waddr,
  output logic                   o_data_wr,
  input  logic                   i_wdata_ack,
  output logic [2:0]             ov_grant_id,
  output logic                   o_lock,
  output logic                   o_err_pulse
);

  localparam logic [1:0] TYPE_HEAD = 2'b01;
  localparam logic [1:0] TYPE_TAIL = 2'b10;
  localparam int         WPAD      = 8 * 134;
  localparam int         APAD      = 8 * 16;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    ISSUE     = 2'b01,
    WAIT_NEXT = 2'b10
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [2:0]    rr_ptr;
  logic [2:0]    rr_nxt;
  logic [7:0]    tmo_cnt;
  logic [7:0]    tmo_nxt;
  logic [133:0]  wdata_nxt;
  logic [15:0]   waddr_nxt;
  logic          wr_nxt;
  logic          lock_nxt;
  logic [2:0]    grant_nxt;
  logic [7:0]    ack_pad;
  logic          err_c;

  // Requester inputs are padded to 8 lanes so a 3-bit index always stays in range.
  logic [WPAD-1:0] wdata_pad;
  logic [APAD-1:0] waddr_pad;
  logic [7:0]      wr_pad;
  logic [133:0]    word [8];
  logic [15:0]     addr [8];
  logic [7:0]      head_pad;
  logic [7:0]      drop_pad;
  logic            head_found;
  logic [2:0]      head_sel;
  logic            drop_found;
  logic [2:0]      drop_sel;
  logic [2:0]      scan_idx;

  function automatic logic [2:0] wrap_inc(input logic [2:0] idx);
    if (idx == 3'(NUM_REQ - 1)) begin
      return 3'd0;
    end else begin
      return idx + 3'd1;
    end
  endfunction

  assign wdata_pad = WPAD'(iv_wdata);
  assign waddr_pad = APAD'(iv_data_waddr);
  assign wr_pad    = 8'(i_data_wr);

  // Slice requester lanes and classify head versus non-head requests.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      word[k]     = wdata_pad[k*134 +: 134];
      addr[k]     = waddr_pad[k*16 +: 16];
      head_pad[k] = wr_pad[k] && (word[k][133:132] == TYPE_HEAD);
      drop_pad[k] = wr_pad[k] && (word[k][133:132] != TYPE_HEAD);
    end
  end

  // Round-robin head search starting at rr_ptr, plus lowest-index drop candidate.
  always_comb begin
    head_found = 1'b0;
    head_sel   = 3'd0;
    drop_found = 1'b0;
    drop_sel   = 3'd0;
    scan_idx   = rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!head_found && head_pad[scan_idx]) begin
        head_found = 1'b1;
        head_sel   = scan_idx;
      end else begin
        head_found = head_found;
      end
      scan_idx = wrap_inc(scan_idx);
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (drop_pad[i]) begin
        drop_found = 1'b1;
        drop_sel   = 3'(i);
      end else begin
        drop_found = drop_found;
      end
    end
  end

  // Next-state and next-output logic of the lock FSM.
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    tmo_nxt   = tmo_cnt;
    wdata_nxt = ov_wdata;
    waddr_nxt = ov_data_waddr;
    wr_nxt    = o_data_wr;
    lock_nxt  = o_lock;
    grant_nxt = ov_grant_id;
    ack_pad   = 8'd0;
    err_c     = 1'b0;
    case (state)
      IDLE: begin
        if (head_found) begin
          wdata_nxt = word[head_sel];
          waddr_nxt = addr[head_sel];
          wr_nxt    = 1'b1;
          lock_nxt  = 1'b1;
          grant_nxt = head_sel;
          state_nxt = ISSUE;
        end else if (drop_found) begin
          ack_pad[drop_sel] = 1'b1;
          err_c             = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      ISSUE: begin
        if (i_wdata_ack && o_data_wr) begin
          ack_pad[ov_grant_id] = 1'b1;
          wr_nxt               = 1'b0;
          if (ov_wdata[133:132] == TYPE_TAIL) begin
            state_nxt = IDLE;
            rr_nxt    = wrap_inc(ov_grant_id);
            lock_nxt  = 1'b0;
          end else begin
            state_nxt = WAIT_NEXT;
            tmo_nxt   = 8'd0;
          end
        end else begin
          state_nxt = ISSUE;
        end
      end
      WAIT_NEXT: begin
        if (wr_pad[ov_grant_id]) begin
          wdata_nxt = word[ov_grant_id];
          waddr_nxt = addr[ov_grant_id];
          wr_nxt    = 1'b1;
          state_nxt = ISSUE;
        end else if (tmo_cnt == 8'(LOCK_TMO)) begin
          err_c     = 1'b1;
          state_nxt = IDLE;
          rr_nxt    = wrap_inc(ov_grant_id);
          lock_nxt  = 1'b0;
          tmo_nxt   = 8'd0;
        end else begin
          tmo_nxt = tmo_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        wr_nxt    = 1'b0;
        lock_nxt  = 1'b0;
      end
    endcase
  end

  // Acks and error pulses are suppressed while reset is asserted.
  always_comb begin
    if (i_rst) begin
      o_wdata_ack = '0;
      o_err_pulse = 1'b0;
    end else begin
      o_wdata_ack = ack_pad[NUM_REQ-1:0];
      o_err_pulse = err_c;
    end
  end

  // State, pointer and registered output updates.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      rr_ptr        <= 3'd0;
      tmo_cnt       <= 8'd0;
      ov_wdata      <= 134'd0;
      ov_data_waddr <= 16'd0;
      o_data_wr     <= 1'b0;
      o_lock        <= 1'b0;
      ov_grant_id   <= 3'd0;
    end else begin
      state         <= state_nxt;
      rr_ptr        <= rr_nxt;
      tmo_cnt       <= tmo_nxt;
      ov_wdata      <= wdata_nxt;
      ov_data_waddr <= waddr_nxt;
      o_data_wr     <= wr_nxt;
      o_lock        <= lock_nxt;
      ov_grant_id   <= grant_nxt;
    end
  end

endmodule
